// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the K=3 rate-1/2 hard-decision Viterbi decoder: PM init,
// one ACS/survivor write per accepted symbol, then a full-frame traceback sweep.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic              pm_init,
  output logic              acs_en,
  output logic              sm_wr_en,
  output logic [ADDR_W-1:0] sm_wr_addr,
  output logic              tb_rd_en,
  output logic [ADDR_W-1:0] tb_rd_addr,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ACS, S_TB, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] tb_addr_q, tb_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              kill;
  logic              accept;

  // abort (and a synchronous reset) squash every strobe in the cycle it is seen,
  // so a symbol presented alongside it is never consumed.
  assign kill      = reset | abort;
  assign sym_ready = (state_q == S_ACS) & ~kill;
  assign accept    = sym_ready & sym_valid;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    tb_addr_d   = tb_addr_q;
    wr_addr_d   = wr_addr_q;
    frame_cnt_d = frame_cnt_q;
    if (accept) wr_addr_d = step_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: begin
        step_d  = '0;
        state_d = S_ACS;
      end
      S_ACS: if (accept) begin
        if (step_q == LAST) begin
          step_d    = '0;
          tb_addr_d = LAST;
          state_d   = S_TB;
        end else begin
          step_d = step_q + ONE;
        end
      end
      S_TB: begin
        if (tb_addr_q == '0) state_d = S_DONE;
        else                 tb_addr_d = tb_addr_q - ONE;
      end
      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d     = S_IDLE;
      frame_cnt_d = frame_cnt_q;
      step_d      = step_q;
      tb_addr_d   = tb_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      tb_addr_q   <= '0;
      wr_addr_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tb_addr_q   <= tb_addr_d;
      wr_addr_q   <= wr_addr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // pm_init only exists in INIT and acs_en only in ACS, so they never overlap.
  assign pm_init    = (state_q == S_INIT) & ~kill;
  assign acs_en     = accept;
  assign sm_wr_en   = accept;
  assign sm_wr_addr = accept ? step_q : wr_addr_q;
  assign tb_rd_en   = (state_q == S_TB) & ~kill;
  assign tb_rd_addr = tb_addr_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE) & ~kill;
  assign frame_cnt  = frame_cnt_q;

endmodule
